// File: rtl/bullet_line_renderer_pkg.sv
`default_nettype none
// ============================================================================
// Module  : bullet_line_renderer_pkg
// Brief   : Shared field layout of the bullet state word, sprite constants,
//           scanline slot record and scanner state encoding.
// Revision: 1.0 - initial release
// ============================================================================
package bullet_line_renderer_pkg;

    // Bit positions inside one 32-bit bullet state word
    localparam int c_PAD_BIT    = 31;
    localparam int c_TYPE_MSB   = 30;
    localparam int c_TYPE_LSB   = 29;
    localparam int c_ACTIVE_BIT = 28;
    localparam int c_X_MSB      = 27;
    localparam int c_X_LSB      = 18;
    localparam int c_Y_MSB      = 17;
    localparam int c_Y_LSB      = 8;
    localparam int c_DIR_MSB    = 7;
    localparam int c_DIR_LSB    = 6;
    localparam int c_ROW_MSB    = 5;
    localparam int c_ROW_LSB    = 3;
    localparam int c_COL_MSB    = 2;
    localparam int c_COL_LSB    = 0;

    localparam logic [1:0]  c_OBJ_TYPE_BULLET = 2'b01;
    localparam logic [11:0] c_TRANSPARENT     = 12'h000;

    // One bullet selected for the upcoming scanline
    typedef struct packed {
        logic [9:0] x;
        logic [2:0] py;
        logic [2:0] rom_row;
        logic [2:0] rom_col;
    } slot_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_SWAP = 2'd2
    } scan_state_t;

    // Build a slot record from a state word for the given target line.
    // Only the low three bits of (target - y) are needed because the
    // sprite is eight lines tall.
    function automatic slot_t make_slot(input logic [31:0] word,
                                        input logic [10:0] target);
        slot_t s;
        s.x       = word[c_X_MSB:c_X_LSB];
        s.py      = target[2:0] - word[c_Y_LSB+2:c_Y_LSB];
        s.rom_row = word[c_ROW_MSB:c_ROW_LSB];
        s.rom_col = word[c_COL_MSB:c_COL_LSB];
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bullet_line_renderer_scanner.sv
`default_nettype none
// ============================================================================
// Module  : bullet_line_scanner
// Brief   : Horizontal-blank scanner. Walks every bullet state word once per
//           line, collects up to SLOTS bullets touching the next line into a
//           back bank, then swaps it into the display bank.
// Revision: 1.0 - initial release
// ============================================================================
module bullet_line_scanner
    import bullet_line_renderer_pkg::*;
#(
    parameter int MAX_BULLETS = 8,
    parameter int SLOTS       = 4,
    parameter int BULLET_SIZE = 8,
    parameter int V_ACTIVE    = 480,
    parameter int CNT_W       = $clog2(SLOTS + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      i_bullet_state [0:MAX_BULLETS-1],
    input  logic [9:0]       i_vcount,
    input  logic             i_line_start,
    output slot_t            o_disp [0:SLOTS-1],
    output logic [CNT_W-1:0] o_disp_cnt,
    output logic             o_scan_busy,
    output logic             o_overflow
);

    localparam int c_IDX_W = (MAX_BULLETS > 1) ? $clog2(MAX_BULLETS) : 1;
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(MAX_BULLETS - 1);
    localparam logic [CNT_W-1:0]   c_SLOTS_CNT = CNT_W'(SLOTS);

    scan_state_t          r_state;
    logic [c_IDX_W-1:0]   r_idx;
    logic [10:0]          r_target;
    slot_t                r_back [0:SLOTS-1];
    logic [CNT_W-1:0]     r_back_cnt;
    slot_t                r_disp [0:SLOTS-1];
    logic [CNT_W-1:0]     r_disp_cnt;
    logic                 r_ovf_acc;
    logic                 r_scan_busy;
    logic                 r_overflow;

    logic [31:0]          w_word;
    logic [10:0]          w_y;
    logic [10:0]          w_next_line;
    logic                 w_qual;
    slot_t                w_slot;
    logic [2:0]           w_unused_fields;

    assign w_word          = i_bullet_state[r_idx];
    assign w_y             = {1'b0, w_word[c_Y_MSB:c_Y_LSB]};
    assign w_next_line     = {1'b0, i_vcount} + 11'd1;
    assign w_slot          = make_slot(w_word, r_target);
    // pad and dir are carried in the word but not needed for drawing
    assign w_unused_fields = {w_word[c_PAD_BIT], w_word[c_DIR_MSB:c_DIR_LSB]};

    // Word qualifies when it is an active bullet whose rows cover the target
    assign w_qual = (w_word[c_TYPE_MSB:c_TYPE_LSB] == c_OBJ_TYPE_BULLET)
                 && w_word[c_ACTIVE_BIT]
                 && (w_y <= r_target)
                 && (r_target < (w_y + 11'(BULLET_SIZE)));

    // Scanner FSM with back/display slot banks and registered status flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_target    <= '0;
            r_back_cnt  <= '0;
            r_disp_cnt  <= '0;
            r_ovf_acc   <= 1'b0;
            r_scan_busy <= 1'b0;
            r_overflow  <= 1'b0;
            for (int s = 0; s < SLOTS; s++) begin
                r_back[s] <= '0;
                r_disp[s] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_line_start) begin
                        r_target   <= w_next_line;
                        r_idx      <= '0;
                        r_back_cnt <= '0;
                        r_ovf_acc  <= 1'b0;
                        // Lines below the visible area swap in an empty bank
                        if (w_next_line >= 11'(V_ACTIVE)) begin
                            r_state <= S_SWAP;
                        end else begin
                            r_state     <= S_SCAN;
                            r_scan_busy <= 1'b1;
                        end
                    end
                end
                S_SCAN: begin
                    if (w_qual) begin
                        if (r_back_cnt < c_SLOTS_CNT) begin
                            for (int s = 0; s < SLOTS; s++) begin
                                if (s == int'(r_back_cnt)) begin
                                    r_back[s] <= w_slot;
                                end
                            end
                            r_back_cnt <= r_back_cnt + 1'b1;
                        end else begin
                            r_ovf_acc <= 1'b1;
                        end
                    end
                    if (r_idx == c_LAST_IDX) begin
                        r_state     <= S_SWAP;
                        r_scan_busy <= 1'b0;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                S_SWAP: begin
                    for (int s = 0; s < SLOTS; s++) begin
                        r_disp[s] <= r_back[s];
                    end
                    r_disp_cnt <= r_back_cnt;
                    r_overflow <= r_ovf_acc;
                    r_state    <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_disp      = r_disp;
    assign o_disp_cnt  = r_disp_cnt;
    assign o_scan_busy = r_scan_busy;
    assign o_overflow  = r_overflow;

endmodule
`default_nettype wire

// File: rtl/bullet_line_renderer.sv
`default_nettype none
// ============================================================================
// Module  : bullet_line_renderer
// Brief   : Bullet sprite renderer. Uses the scanner's display bank to run a
//           two-stage pixel pipeline: slot select + ROM address, then colour
//           qualification against the transparent ROM word.
// Revision: 1.0 - initial release
// ============================================================================
module bullet_line_renderer
    import bullet_line_renderer_pkg::*;
#(
    parameter int MAX_BULLETS = 8,
    parameter int SLOTS       = 4,
    parameter int BULLET_SIZE = 8,
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] bullet_state [0:MAX_BULLETS-1],
    input  logic [9:0]  hcount,
    input  logic [9:0]  vcount,
    input  logic        line_start,
    output logic [11:0] rom_addr,
    input  logic [11:0] rom_data,
    output logic        pix_valid,
    output logic [11:0] pix_color,
    output logic [9:0]  pix_x,
    output logic        scan_busy,
    output logic        overflow
);

    localparam int c_CNT_W = $clog2(SLOTS + 1);

    slot_t               w_disp [0:SLOTS-1];
    logic [c_CNT_W-1:0]  w_disp_cnt;
    logic [10:0]         w_h;
    logic                w_hit;
    logic [11:0]         w_addr;
    logic                w_opaque;

    logic [11:0]         r_last_addr;
    logic                r_hit;
    logic [9:0]          r_hcount;
    logic                r_pix_valid;
    logic [11:0]         r_pix_color;
    logic [9:0]          r_pix_x;

    bullet_line_scanner #(
        .MAX_BULLETS (MAX_BULLETS),
        .SLOTS       (SLOTS),
        .BULLET_SIZE (BULLET_SIZE),
        .V_ACTIVE    (V_ACTIVE),
        .CNT_W       (c_CNT_W)
    ) u_scanner (
        .clk            (clk),
        .reset          (reset),
        .i_bullet_state (bullet_state),
        .i_vcount       (vcount),
        .i_line_start   (line_start),
        .o_disp         (w_disp),
        .o_disp_cnt     (w_disp_cnt),
        .o_scan_busy    (scan_busy),
        .o_overflow     (overflow)
    );

    assign w_h = {1'b0, hcount};

    // Stage 0: lowest-numbered display slot covering this column wins
    always_comb begin
        w_hit  = 1'b0;
        w_addr = '0;
        if (w_h < 11'(H_ACTIVE)) begin
            for (int s = SLOTS - 1; s >= 0; s--) begin
                if ((s < int'(w_disp_cnt))
                    && (w_h >= {1'b0, w_disp[s].x})
                    && (w_h < ({1'b0, w_disp[s].x} + 11'(BULLET_SIZE)))) begin
                    w_hit  = 1'b1;
                    w_addr = {w_disp[s].rom_row, w_disp[s].rom_col,
                              w_disp[s].py, hcount[2:0] - w_disp[s].x[2:0]};
                end
            end
        end
    end

    // Without a hit the ROM address keeps its last driven value
    assign rom_addr = w_hit ? w_addr : r_last_addr;
    assign w_opaque = r_hit && (rom_data != c_TRANSPARENT);

    // Stage 0/1 registers: hit and column, then qualified colour output
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last_addr <= '0;
            r_hit       <= 1'b0;
            r_hcount    <= '0;
            r_pix_valid <= 1'b0;
            r_pix_color <= '0;
            r_pix_x     <= '0;
        end else begin
            if (w_hit) begin
                r_last_addr <= w_addr;
            end
            r_hit       <= w_hit;
            r_hcount    <= hcount;
            r_pix_valid <= w_opaque;
            r_pix_color <= w_opaque ? rom_data : c_TRANSPARENT;
            r_pix_x     <= r_hcount;
        end
    end

    assign pix_valid = r_pix_valid;
    assign pix_color = r_pix_color;
    assign pix_x     = r_pix_x;

endmodule
`default_nettype wire
